// File: rtl/iic_gain_op_sequencer_if.sv
// Fabric op bus between the gain-op sequencer and the IIC fabric op FIFO
// write port. One transfer per cycle where trans_vld && trans_rdy.
`timescale 1ns/1ps

interface iic_gain_op_sequencer_if;
    logic       trans_vld;
    logic       trans_rdy;
    logic [7:0] trans_data;
    logic       trans_start;
    logic       trans_stop;
    logic       trans_rnw;
    logic       trans_lock;

    // Producer side: the sequencer presents ops and watches FIFO space.
    modport master (
        output trans_vld,
        output trans_data,
        output trans_start,
        output trans_stop,
        output trans_rnw,
        output trans_lock,
        input  trans_rdy
    );

    // Consumer side: the op FIFO write port.
    modport slave (
        input  trans_vld,
        input  trans_data,
        input  trans_start,
        input  trans_stop,
        input  trans_rnw,
        input  trans_lock,
        output trans_rdy
    );
endinterface

// File: rtl/iic_gain_op_sequencer.sv
// Turns a register-write request (8-bit register address, 16-bit value)
// into the byte-level IIC op sequence ADDR, REG, [DHI], DLO, holding the
// bus lock until the last byte. One request can wait in a pending slot
// while a transaction is in flight; a newer request replaces it.
`timescale 1ns/1ps

module iic_gain_op_sequencer #(
    parameter logic [6:0] DEV_ADDR       = 7'h20,
    parameter int         NUM_DATA_BYTES = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cmd_load,
    input  logic [7:0]                     cmd_reg,
    input  logic [15:0]                    cmd_data,
    output logic                           cmd_busy,
    output logic                           cmd_drop,
    iic_gain_op_sequencer_if.master        trans
);

    // Only one- or two-byte register values are meaningful for this device.
    if (!(NUM_DATA_BYTES == 1 || NUM_DATA_BYTES == 2)) begin : g_bad_num_data_bytes
        $error("iic_gain_op_sequencer: NUM_DATA_BYTES must be 1 or 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_REG,
        S_DHI,
        S_DLO
    } state_e;

    // Sequencer state and request storage.
    state_e      state_q,     state_d;
    logic [7:0]  act_reg_q,   act_reg_d;
    logic [15:0] act_data_q,  act_data_d;
    logic [7:0]  pend_reg_q,  pend_reg_d;
    logic [15:0] pend_data_q, pend_data_d;
    logic        pend_vld_q,  pend_vld_d;

    // Registered outputs, computed from the next state so that no input
    // reaches an output port without passing through a flop.
    logic        vld_q,   vld_d;
    logic [7:0]  data_q,  data_d;
    logic        start_q, start_d;
    logic        stop_q,  stop_d;
    logic        lock_q,  lock_d;
    logic        busy_q,  busy_d;
    logic        drop_q,  drop_d;

    logic        xfer;
    logic        last_xfer;

    // All state and outputs return to idle values on reset; no STOP is sent.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: flops take non-blocking assignments so every register samples
        // pre-edge values regardless of statement order.
        if (rst) begin
            state_q     <= S_IDLE;
            act_reg_q   <= '0;
            act_data_q  <= '0;
            pend_reg_q  <= '0;
            pend_data_q <= '0;
            pend_vld_q  <= 1'b0;
            vld_q       <= 1'b0;
            data_q      <= '0;
            start_q     <= 1'b0;
            stop_q      <= 1'b0;
            lock_q      <= 1'b0;
            busy_q      <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            act_reg_q   <= act_reg_d;
            act_data_q  <= act_data_d;
            pend_reg_q  <= pend_reg_d;
            pend_data_q <= pend_data_d;
            pend_vld_q  <= pend_vld_d;
            vld_q       <= vld_d;
            data_q      <= data_d;
            start_q     <= start_d;
            stop_q      <= stop_d;
            lock_q      <= lock_d;
            busy_q      <= busy_d;
            drop_q      <= drop_d;
        end
    end

    // Next state, request bookkeeping and the op fields for the next cycle.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        act_reg_d   = act_reg_q;
        act_data_d  = act_data_q;
        pend_reg_d  = pend_reg_q;
        pend_data_d = pend_data_q;
        pend_vld_d  = pend_vld_q;
        drop_d      = 1'b0;

        xfer        = (state_q != S_IDLE) && trans.trans_rdy;
        last_xfer   = (state_q == S_DLO) && trans.trans_rdy;

        if (state_q == S_IDLE) begin
            // Pending slot is always empty here: it is only filled while busy
            // and is consumed by the final transfer.
            if (cmd_load) begin
                act_reg_d  = cmd_reg;
                act_data_d = cmd_data;
                state_d    = S_ADDR;
            end
        end else if (last_xfer) begin
            // Pick the next transaction so it starts with no idle gap. A load
            // arriving now is newer than anything pending, so it wins.
            if (cmd_load) begin
                act_reg_d  = cmd_reg;
                act_data_d = cmd_data;
                drop_d     = pend_vld_q;
                pend_vld_d = 1'b0;
                state_d    = S_ADDR;
            end else if (pend_vld_q) begin
                act_reg_d  = pend_reg_q;
                act_data_d = pend_data_q;
                pend_vld_d = 1'b0;
                state_d    = S_ADDR;
            end else begin
                state_d    = S_IDLE;
            end
        end else begin
            if (xfer) begin
                unique case (state_q)
                    S_ADDR:  state_d = S_REG;
                    S_REG:   state_d = (NUM_DATA_BYTES == 1) ? S_DLO : S_DHI;
                    S_DHI:   state_d = S_DLO;
                    default: state_d = state_q;
                endcase
            end
            // Latest request wins; an overwritten pending request is reported.
            if (cmd_load) begin
                pend_reg_d  = cmd_reg;
                pend_data_d = cmd_data;
                pend_vld_d  = 1'b1;
                drop_d      = pend_vld_q;
            end
        end

        vld_d   = 1'b0;
        data_d  = 8'h00;
        start_d = 1'b0;
        stop_d  = 1'b0;
        lock_d  = 1'b0;
        unique case (state_d)
            S_ADDR: begin
                vld_d   = 1'b1;
                data_d  = {DEV_ADDR, 1'b0};
                start_d = 1'b1;
                lock_d  = 1'b1;
            end
            S_REG: begin
                vld_d   = 1'b1;
                data_d  = act_reg_d;
                lock_d  = 1'b1;
            end
            S_DHI: begin
                vld_d   = 1'b1;
                data_d  = act_data_d[15:8];
                lock_d  = 1'b1;
            end
            S_DLO: begin
                vld_d   = 1'b1;
                data_d  = act_data_d[7:0];
                stop_d  = 1'b1;
            end
            default: begin
                vld_d   = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE) || pend_vld_d;
    end

    // Drive the op bus and status from the output flops.
    assign trans.trans_vld   = vld_q;
    assign trans.trans_data  = data_q;
    assign trans.trans_start = start_q;
    assign trans.trans_stop  = stop_q;
    assign trans.trans_rnw   = 1'b0;
    assign trans.trans_lock  = lock_q;
    assign cmd_busy          = busy_q;
    assign cmd_drop          = drop_q;

endmodule
